// File: rtl/laser_pkg.sv
// Shared types and constants for the laser point feeder and its coverage checker.
package laser_pkg;

  localparam int NPTS  = 40;
  localparam int CW    = 4;
  localparam int IDX_W = 6;

  localparam logic [IDX_W-1:0] NPTS_L   = IDX_W'(NPTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);
  localparam logic [8:0]       RAD_SQ   = 9'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_SCORE,
    ST_REPORT
  } state_e;

  // Squared Euclidean distance; worst case 2*15^2 = 450 still fits 9 bits.
  function automatic logic [8:0] dist_sq(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                         input logic [CW-1:0] bx, input logic [CW-1:0] by);
    logic [8:0] dx;
    logic [8:0] dy;
    dx = (ax > bx) ? 9'(ax - bx) : 9'(bx - ax);
    dy = (ay > by) ? 9'(ay - by) : 9'(by - ay);
    return dx * dx + dy * dy;
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational check: is one point within radius 4 of either of two centres.
module laser_cover_chk
  import laser_pkg::*;
(
  input  logic [CW-1:0] px_i,
  input  logic [CW-1:0] py_i,
  input  logic [CW-1:0] c1x_i,
  input  logic [CW-1:0] c1y_i,
  input  logic [CW-1:0] c2x_i,
  input  logic [CW-1:0] c2y_i,
  output logic          covered_o
);

  always_comb begin
    covered_o = (dist_sq(px_i, py_i, c1x_i, c1y_i) <= RAD_SQ) ||
                (dist_sq(px_i, py_i, c2x_i, c2y_i) <= RAD_SQ);
  end

endmodule

// File: rtl/laser_point_feeder.sv
// Frame store, streamer to the coverage engine, and re-scorer of the returned centres.
// Optional WAIT_DONE watchdog is enabled with `define LASER_FEEDER_TIMEOUT_EN.
module laser_point_feeder
  import laser_pkg::*;
`ifdef LASER_FEEDER_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 65535
)
`endif
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [CW-1:0]    wr_x_i,
  input  logic [CW-1:0]    wr_y_i,
  input  logic             start_i,
  output logic [CW-1:0]    x_o,
  output logic [CW-1:0]    y_o,
  output logic             eng_rst_o,
  input  logic             done_i,
  input  logic [CW-1:0]    c1x_i,
  input  logic [CW-1:0]    c1y_i,
  input  logic [CW-1:0]    c2x_i,
  input  logic [CW-1:0]    c2y_i,
  output logic             busy_o,
  output logic             res_valid_o,
  output logic [CW-1:0]    res_c1x_o,
  output logic [CW-1:0]    res_c1y_o,
  output logic [CW-1:0]    res_c2x_o,
  output logic [CW-1:0]    res_c2y_o,
  output logic [IDX_W-1:0] res_count_o,
  output logic             res_err_o
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   cov_q;
  logic [CW-1:0]      x_q, y_q;
  logic               eng_rst_q, busy_q, res_valid_q;
  logic [CW-1:0]      c1x_q, c1y_q, c2x_q, c2y_q;
  logic [IDX_W-1:0]   res_count_q;
  logic [2*CW-1:0]    mem_q [NPTS];
  logic [2*CW-1:0]    rd_pt;
  logic               covered;

  // Point memory deliberately has no reset so a frame survives RST_N.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && wr_en_i && wr_addr_i < NPTS_L) begin
      mem_q[wr_addr_i] <= {wr_x_i, wr_y_i};
    end
  end

  always_comb begin
    rd_pt = '0;
    if (idx_q < NPTS_L) rd_pt = mem_q[idx_q];
  end

  laser_cover_chk u_cover_chk (
    .px_i      (rd_pt[2*CW-1:CW]),
    .py_i      (rd_pt[CW-1:0]),
    .c1x_i     (c1x_q),
    .c1y_i     (c1y_q),
    .c2x_i     (c2x_q),
    .c2y_i     (c2y_q),
    .covered_o (covered)
  );

`ifdef LASER_FEEDER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_q;
  logic        err_q;
  logic        res_err_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cov_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      eng_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      res_count_q <= '0;
`ifdef LASER_FEEDER_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q      <= ST_SEND;
            busy_q       <= 1'b1;
            eng_rst_q    <= 1'b0;
            {x_q, y_q}   <= mem_q[0];
            idx_q        <= IDX_W'(1);
`ifdef LASER_FEEDER_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
          end
        end
        ST_SEND: begin
          if (idx_q == NPTS_L) begin
            x_q     <= '0;
            y_q     <= '0;
            state_q <= ST_WAIT_DONE;
`ifdef LASER_FEEDER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end else begin
            {x_q, y_q} <= rd_pt;
            idx_q      <= idx_q + IDX_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (done_i) begin
            c1x_q     <= c1x_i;
            c1y_q     <= c1y_i;
            c2x_q     <= c2x_i;
            c2y_q     <= c2y_i;
            eng_rst_q <= 1'b1;
            idx_q     <= '0;
            cov_q     <= '0;
            state_q   <= ST_SCORE;
          end
`ifdef LASER_FEEDER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            c1x_q     <= '0;
            c1y_q     <= '0;
            c2x_q     <= '0;
            c2y_q     <= '0;
            eng_rst_q <= 1'b1;
            cov_q     <= '0;
            err_q     <= 1'b1;
            state_q   <= ST_REPORT;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        ST_SCORE: begin
          cov_q <= cov_q + IDX_W'(covered);
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          res_valid_q <= 1'b1;
          res_count_q <= cov_q;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
`ifdef LASER_FEEDER_TIMEOUT_EN
          res_err_q   <= err_q;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign eng_rst_o   = eng_rst_q;
  assign busy_o      = busy_q;
  assign res_valid_o = res_valid_q;
  assign res_c1x_o   = c1x_q;
  assign res_c1y_o   = c1y_q;
  assign res_c2x_o   = c2x_q;
  assign res_c2y_o   = c2y_q;
  assign res_count_o = res_count_q;
`ifdef LASER_FEEDER_TIMEOUT_EN
  assign res_err_o   = res_err_q;
`else
  assign res_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_laser_point_feeder.sv
// Randomized bench for laser_point_feeder with a behavioural frame/engine model.
module tb_laser_point_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, start, done;
  logic [5:0] wr_addr;
  logic [3:0] wr_x, wr_y, c1x, c1y, c2x, c2y;
  logic [3:0] x, y, rc1x, rc1y, rc2x, rc2y;
  logic       eng_rst, busy, res_valid, res_err;
  logic [5:0] res_count;

  int n_chk  = 0;
  int n_pass = 0;
  int mx[40];
  int my[40];
  int cnt;

  always #5 clk = ~clk;

  laser_point_feeder dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_x_i(wr_x), .wr_y_i(wr_y), .start_i(start), .x_o(x), .y_o(y),
    .eng_rst_o(eng_rst), .done_i(done), .c1x_i(c1x), .c1y_i(c1y),
    .c2x_i(c2x), .c2y_i(c2y), .busy_o(busy), .res_valid_o(res_valid),
    .res_c1x_o(rc1x), .res_c1y_o(rc1y), .res_c2x_o(rc2x), .res_c2y_o(rc2y),
    .res_count_o(res_count), .res_err_o(res_err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame();
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_x = 4'(mx[i]); wr_y = 4'(my[i]);
      tick();
    end
    // Out-of-range addresses must not alias onto real entries.
    for (int i = 40; i < 64; i++) begin
      wr_addr = 6'(i); wr_x = 4'(mx[i % 40] + 1); wr_y = 4'(my[i % 40] + 3);
      tick();
    end
    wr_en = 1'b0;
  endtask

  function automatic int ref_count(input int ax, input int ay, input int bx, input int by);
    int n = 0;
    for (int k = 0; k < 40; k++) begin
      if ((mx[k]-ax)*(mx[k]-ax) + (my[k]-ay)*(my[k]-ay) <= 16 ||
          (mx[k]-bx)*(mx[k]-bx) + (my[k]-by)*(my[k]-by) <= 16) n++;
    end
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_xy"}, int'({x, y}), 0);
    check_eq({tag, "_eng_rst"}, int'(eng_rst), 1);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_res_valid"}, int'(res_valid), 0);
    check_eq({tag, "_res_c"}, int'({rc1x, rc1y, rc2x, rc2y}), 0);
    check_eq({tag, "_res_count"}, int'(res_count), 0);
    check_eq({tag, "_res_err"}, int'(res_err), 0);
  endtask

  task automatic run_frame(input int ax, input int ay, input int bx, input int by,
                           input int dly, input bit glitch, output int got_cnt);
    int n;
    int exp_c;
    exp_c = ({ax[3:0], ay[3:0], bx[3:0], by[3:0]});
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_eng_rst", int'(eng_rst), 0);
    check_eq("start_busy", int'(busy), 1);
    for (int k = 0; k < 40; k++) begin
      check_eq("stream_xy", int'({x, y}), (mx[k] << 4) | my[k]);
      if (glitch && k == 5) begin
        wr_en = 1'b1; wr_addr = 6'd3; wr_x = 4'(mx[3] + 1); wr_y = 4'(my[3] + 2);
        start = 1'b1; done = 1'b1;
      end
      tick();
      wr_en = 1'b0; start = 1'b0; done = 1'b0;
    end
    check_eq("post_send_xy", int'({x, y}), 0);
    check_eq("post_send_eng_rst", int'(eng_rst), 0);
    for (int d = 0; d < dly; d++) begin
      if (glitch && d == 2) begin
        wr_en = 1'b1; wr_addr = 6'd7; wr_x = 4'(mx[7] + 5); wr_y = 4'(my[7]); start = 1'b1;
      end
      tick();
      wr_en = 1'b0; start = 1'b0;
    end
    done = 1'b1; c1x = 4'(ax); c1y = 4'(ay); c2x = 4'(bx); c2y = 4'(by);
    tick();
    done = 1'b0;
    c1x = 4'($urandom); c1y = 4'($urandom); c2x = 4'($urandom); c2y = 4'($urandom);
    check_eq("done_eng_rst", int'(eng_rst), 1);
    check_eq("done_centres", int'({rc1x, rc1y, rc2x, rc2y}), exp_c);
    n = 0;
    while (n < 200) begin
      if (glitch && n == 10) done = 1'b1;
      if (glitch && n == 12) begin
        wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'(mx[0] + 1); wr_y = 4'(my[0]);
      end
      if (n == 40) start = 1'b1;
      tick();
      n++;
      done = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (res_valid) break;
    end
    check_eq("latency", n, 41);
    check_eq("res_count", int'(res_count), ref_count(ax, ay, bx, by));
    check_eq("res_err", int'(res_err), 0);
    check_eq("report_busy", int'(busy), 0);
    check_eq("report_centres", int'({rc1x, rc1y, rc2x, rc2y}), exp_c);
    got_cnt = int'(res_count);
    tick();
    check_eq("valid_one_cycle", int'(res_valid), 0);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_eng_rst", int'(eng_rst), 1);
    check_eq("hold_count", int'(res_count), got_cnt);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; done = 1'b0; wr_addr = '0;
    wr_x = '0; wr_y = '0; c1x = '0; c1y = '0; c2x = '0; c2y = '0;
    repeat (3) tick();
    check_reset_outputs("rst_low");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    for (int i = 0; i < 40; i++) begin mx[i] = i % 16; my[i] = i / 16; end
    write_frame();
    run_frame($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15),
              100, 1'b0, cnt);

    for (int i = 0; i < 40; i++) begin
      case (i / 10)
        0: begin mx[i] = 3;  my[i] = 7;  end
        1: begin mx[i] = 6;  my[i] = 5;  end
        2: begin mx[i] = 6;  my[i] = 6;  end
        default: begin mx[i] = 12; my[i] = 12; end
      endcase
    end
    write_frame();
    run_frame(3, 3, 12, 12, 100, 1'b0, cnt);
    check_eq("score_frame_30", cnt, 30);

    for (int i = 0; i < 40; i++) begin mx[i] = 7; my[i] = 7; end
    write_frame();
    run_frame(5, 5, 9, 9, 20, 1'b1, cnt);
    check_eq("overlap_40", cnt, 40);

    for (int r = 0; r < 4; r++) begin
      int ax, ay, bx, by;
      ax = $urandom_range(15); ay = $urandom_range(15);
      bx = $urandom_range(15); by = $urandom_range(15);
      for (int i = 0; i < 40; i++) begin
        mx[i] = (i % 2 == 0) ? $urandom_range(15) : (ax + $urandom_range(4)) % 16;
        my[i] = (i % 2 == 0) ? $urandom_range(15) : (ay + $urandom_range(4)) % 16;
      end
      write_frame();
      run_frame(ax, ay, bx, by, $urandom_range(50), 1'b1, cnt);
    end

    // Reset in the middle of streaming; the stored frame must survive it.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midsend_rst_eng_rst", int'(eng_rst), 1);
    check_eq("midsend_rst_busy", int'(busy), 0);
    check_eq("midsend_rst_xy", int'({x, y}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("midsend_after");
    run_frame(4, 9, 11, 2, 0, 1'b0, cnt);

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (41) tick();
    seen = 1'b0;
`ifdef LASER_FEEDER_TIMEOUT_EN
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (res_valid) begin seen = 1'b1; break; end
    end
    check_eq("timeout_valid", int'(seen), 1);
    check_eq("timeout_err", int'(res_err), 1);
    check_eq("timeout_count", int'(res_count), 0);
    check_eq("timeout_centres", int'({rc1x, rc1y, rc2x, rc2y}), 0);
    check_eq("timeout_eng_rst", int'(eng_rst), 1);
`else
    for (int i = 0; i < 300; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    check_eq("no_done_valid", int'(seen), 0);
    check_eq("no_done_busy", int'(busy), 1);
    check_eq("no_done_eng_rst", int'(eng_rst), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
